// File: rtl/modadd_arbiter.sv
// modadd_arbiter: round-robin sharing of one external modular adder between two requesters.
// Define MODADD_RANGE_CHECK_EN to flag operands that are not below the modulus M = 2^N_BITS - K.
module modadd_arbiter #(
    parameter int N_BITS    = 7,
    parameter int ADDER_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [N_BITS-1:0] cfg_k,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [N_BITS-1:0] req0_a,
    input  logic [N_BITS-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [N_BITS-1:0] req1_a,
    input  logic [N_BITS-1:0] req1_b,
    output logic [N_BITS-1:0] add_a,
    output logic [N_BITS-1:0] add_b,
    output logic [N_BITS-1:0] add_k,
    input  logic [N_BITS-1:0] add_sum,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [N_BITS-1:0] rsp_sum,
    output logic              rsp_err,
    output logic              busy
);

    // state | meaning
    // IDLE  | accepts a config write or one new request
    // WAIT  | operands held on the adder while its latency elapses
    // RESP  | result held on rsp_* until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADDER_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [N_BITS-1:0] k_reg;
    logic              last_grant;
    logic              grant;
    logic              any_valid;
    logic              accept;
    logic              range_err;
    logic [CNT_W-1:0]  cnt;
    logic [N_BITS-1:0] sel_a;
    logic [N_BITS-1:0] sel_b;

    // Contested cycles go to whoever did not win last; a config write blocks acceptance.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        accept    = (state == IDLE) & ~cfg_we & ~rst & any_valid;
        sel_a     = grant ? req1_a : req0_a;
        sel_b     = grant ? req1_b : req0_b;
    end

    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;
    assign busy       = (state != IDLE);
    assign add_k      = k_reg;

`ifdef MODADD_RANGE_CHECK_EN
    logic [N_BITS:0] mod_m;

    always_comb begin
        mod_m     = {1'b1, {N_BITS{1'b0}}} - {1'b0, k_reg};
        range_err = ({1'b0, sel_a} >= mod_m) | ({1'b0, sel_b} >= mod_m);
    end
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg      <= '0;
            last_grant <= 1'b1;
            add_a      <= '0;
            add_b      <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        k_reg <= cfg_k;
                    end else if (accept) begin
                        add_a      <= sel_a;
                        add_b      <= sel_b;
                        rsp_id     <= grant;
                        rsp_err    <= range_err;
                        last_grant <= grant;
                        cnt        <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_sum   <= add_sum;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modadd_arbiter.sv
// Bench for modadd_arbiter: behavioural adder, round-robin reference model and response scoreboard.
module tb_modadd_arbiter;
    localparam int N_BITS    = 7;
    localparam int ADDER_LAT = 1;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [6:0] cfg_k;
    logic       req0_valid, req0_ready;
    logic [6:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [6:0] req1_a, req1_b;
    logic [6:0] add_a, add_b, add_k, add_sum;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [6:0] rsp_sum;

    modadd_arbiter #(.N_BITS(N_BITS), .ADDER_LAT(ADDER_LAT)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_k(cfg_k),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_k(add_k), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural modular adder
    always_comb add_sum = 7'((int'(add_a) + int'(add_b)) % (128 - int'(add_k)));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    typedef struct {
        int id;
        int sum;
        int err;
    } exp_t;

    exp_t sb[$];
    int   got_id[$];
    int   got_sum[$];
    int   got_err[$];

    // reference model state
    int model_k    = 0;
    int model_last = 1;
    int inflight   = 0;
    int cyc        = 0;
    int acc_cyc    = 0;
    int pv = 0, pr = 0, psum = 0, pid = 0, perr = 0;
    int m_w, m_e0, m_e1, m_a, m_b, m_m, m_err;
    exp_t m_exp;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            model_k    = 0;
            model_last = 1;
            inflight   = 0;
            pv         = 0;
            sb.delete();
        end else begin
            chk("busy", busy, inflight);
            chk("add_k", add_k, model_k);
            m_e0 = 0;
            m_e1 = 0;
            m_w  = 0;
            if (inflight == 0 && !cfg_we && (req0_valid || req1_valid)) begin
                m_w = (req0_valid && req1_valid) ? 1 - model_last : (req1_valid ? 1 : 0);
                if (m_w == 1) m_e1 = 1; else m_e0 = 1;
            end
            chk("req0_ready", req0_ready, m_e0);
            chk("req1_ready", req1_ready, m_e1);
            if (rsp_valid && pv == 0) chk("rsp_latency", cyc - acc_cyc, ADDER_LAT + 1);
            if (pv == 1 && pr == 0) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_sum", rsp_sum, psum);
                chk("hold_id", rsp_id, pid);
                chk("hold_err", rsp_err, perr);
            end
            if (cfg_we && inflight == 0) model_k = cfg_k;
            if (rsp_valid && rsp_ready) begin
                got_id.push_back(rsp_id);
                got_sum.push_back(rsp_sum);
                got_err.push_back(rsp_err);
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    m_exp = sb.pop_front();
                    chk("rsp_id", rsp_id, m_exp.id);
                    chk("rsp_sum", rsp_sum, m_exp.sum);
                    chk("rsp_err", rsp_err, m_exp.err);
                end
                inflight = 0;
            end
            if (m_e0 == 1 || m_e1 == 1) begin
                m_a = (m_w == 1) ? int'(req1_a) : int'(req0_a);
                m_b = (m_w == 1) ? int'(req1_b) : int'(req0_b);
                m_m = 128 - model_k;
`ifdef MODADD_RANGE_CHECK_EN
                m_err = (m_a >= m_m || m_b >= m_m) ? 1 : 0;
`else
                m_err = 0;
`endif
                m_exp.id  = m_w;
                m_exp.sum = (m_a + m_b) % m_m;
                m_exp.err = m_err;
                sb.push_back(m_exp);
                model_last = m_w;
                inflight   = 1;
                acc_cyc    = cyc;
            end
            pv   = rsp_valid;
            pr   = rsp_ready;
            psum = rsp_sum;
            pid  = rsp_id;
            perr = rsp_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_k(input int k);
        cfg_we = 1'b1;
        cfg_k  = 7'(k);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input int who, input int a, input int b);
        bit ok;
        ok = 0;
        if (who == 0) begin req0_valid = 1'b1; req0_a = 7'(a); req0_b = 7'(b); end
        else          begin req1_valid = 1'b1; req1_a = 7'(a); req1_b = 7'(b); end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) ok = 1;
        end
        chk("send_accepted", int'(ok), 1);
        tick();
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n0;
        n0 = got_sum.size();
        for (int i = 0; i < 50 && got_sum.size() == n0; i++) @(negedge clk);
        chk("rsp_arrives", int'(got_sum.size() > n0), 1);
        tick();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic last_rsp(input string nm, input int id, input int sum);
        chk({nm, "_id"}, got_id[got_id.size()-1], id);
        chk({nm, "_sum"}, got_sum[got_sum.size()-1], sum);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s, alt_ok, found, acc0, acc1;
        rst = 1'b1; cfg_we = 1'b0; cfg_k = '0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_add_a", add_a, 0);
        chk("reset_add_b", add_b, 0);
        chk("reset_add_k", add_k, 0);
        chk("reset_busy", busy, 0);
        tick();

        // 1: basic op with K=20
        set_k(20);
        send(0, 69, 45);
        wait_rsp();
        last_rsp("t1", 0, 6);

        // 2: both requesters continuously valid after reset
        rst = 1'b1; tick(); rst = 1'b0;
        set_k(0);
        s = got_id.size();
        req0_valid = 1'b1; req0_a = 7'($urandom_range(0, 127)); req0_b = 7'($urandom_range(0, 127));
        req1_valid = 1'b1; req1_a = 7'd100; req1_b = 7'd50;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc0 = int'(req0_valid && req0_ready);
            acc1 = int'(req1_valid && req1_ready);
            tick();
            if (acc0 == 1) begin req0_a = 7'($urandom_range(0, 127)); req0_b = 7'($urandom_range(0, 127)); end
            if (acc1 == 1) begin req1_a = 7'($urandom_range(0, 127)); req1_b = 7'($urandom_range(0, 127)); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) tick();
        chk("t2_count", int'(got_id.size() - s >= 8), 1);
        alt_ok = (got_id.size() > s && got_id[s] == 0) ? 1 : 0;
        for (int i = s + 1; i < got_id.size(); i++) if (got_id[i] == got_id[i-1]) alt_ok = 0;
        chk("t2_alternate", alt_ok, 1);
        found = -1;
        for (int i = got_id.size() - 1; i >= s; i--) if (got_id[i] == 1) found = got_sum[i];
        chk("t2_req1_sum", found, 22);

        // 3: response backpressure with a held-off requester
        set_k(20);
        rsp_ready = 1'b0;
        send(1, 10, 5);
        req0_valid = 1'b1; req0_a = 7'd3; req0_b = 7'd4;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", rsp_valid, 1);
            chk("t3_sum", rsp_sum, 15);
            chk("t3_id", rsp_id, 1);
            chk("t3_req0_ready", req0_ready, 0);
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_handshake", rsp_valid, 1);
        @(negedge clk);
        chk("t3_next_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_rsp();
        last_rsp("t3b", 0, 7);

        // 4: config write wins over a request, ignored while busy
        cfg_we = 1'b1; cfg_k = 7'd28;
        req0_valid = 1'b1; req0_a = 7'd50; req0_b = 7'd60;
        @(negedge clk);
        chk("t4_cfg_blocks", req0_ready, 0);
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("t4_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        cfg_we = 1'b1; cfg_k = 7'd5;
        @(negedge clk);
        chk("t4_k_wait", add_k, 28);
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("t4_k_after", add_k, 28);
        wait_rsp();
        last_rsp("t4", 0, 10);

        // 5: reset during WAIT, then during RESP
        send(0, 5, 6);
        n0 = got_sum.size();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("t5w_valid", rsp_valid, 0);
        chk("t5w_busy", busy, 0);
        chk("t5w_k", add_k, 0);
        repeat (5) @(negedge clk);
        chk("t5w_no_rsp", got_sum.size(), n0);
        tick();
        set_k(28);
        rsp_ready = 1'b0;
        send(0, 1, 2);
        wait_valid();
        tick();
        n0 = got_sum.size();
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5r_valid", rsp_valid, 0);
        chk("t5r_busy", busy, 0);
        chk("t5r_k", add_k, 0);
        repeat (5) @(negedge clk);
        chk("t5r_no_rsp", got_sum.size(), n0);
        tick();

        // 6: range flag at the modulus boundary
        set_k(20);
        send(0, 108, 1);
        wait_rsp();
`ifdef MODADD_RANGE_CHECK_EN
        chk("t6_err_hi", got_err[got_err.size()-1], 1);
`else
        chk("t6_err_hi", got_err[got_err.size()-1], 0);
`endif
        last_rsp("t6a", 0, 1);
        send(0, 107, 0);
        wait_rsp();
        chk("t6_err_lo", got_err[got_err.size()-1], 0);
        last_rsp("t6b", 0, 107);

        // random traffic; held-off requesters keep operands stable
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc0 = int'(req0_valid && req0_ready);
            acc1 = int'(req1_valid && req1_ready);
            tick();
            if (!req0_valid || acc0 == 1) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = 7'($urandom_range(0, 127)); req0_b = 7'($urandom_range(0, 127));
            end
            if (!req1_valid || acc1 == 1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = 7'($urandom_range(0, 127)); req1_b = 7'($urandom_range(0, 127));
            end
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_k     = 7'($urandom_range(0, 100));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; cfg_we = 1'b0; rsp_ready = 1'b1;
        repeat (10) tick();
        chk("drain_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
